div_ratio_ctrl: RTL and testbench

- Run-time controller for the divider cores. It accepts divide-ratio requests over a valid/ready handshake and rejects illegal ratios.
- For a legal ratio it steers the odd core (odd N) or the even core (even N) and programs its count.
- It stops the output at a low phase, pulses the core reset, waits one full output period, then re-enables the output and flags lock.
- Sits between the register/config interface and the even/odd divider pair plus output mux/gate.

---
 rtl/div_ratio_ctrl_if.sv | 11 +
 rtl/div_ratio_ctrl.sv | 153 +++++++++++++++
 tb/tb_div_ratio_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/div_ratio_ctrl_if.sv
// Request channel between the register/config block and the divider ratio controller.
interface div_ratio_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_div;

  modport master (output req_valid, output req_div, input req_ready);
  modport slave  (input req_valid, input req_div, output req_ready);
endinterface

// File: rtl/div_ratio_ctrl.sv
// Run-time ratio controller for the even/odd divider pair: validates requests, drains the
// output at a low phase, pulses the core reset, lets one output period settle, then locks.
module div_ratio_ctrl #(
  parameter int WIDTH   = 8,
  parameter int RST_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  div_ratio_ctrl_if.slave  req,
  input  logic             i_div_in,
  output logic [WIDTH-1:0] o_div_p,
  output logic             o_odd_sel,
  output logic             o_core_rst,
  output logic             o_out_en,
  output logic             o_locked,
  output logic             o_err
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, APPLY, SETTLE} state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_curN, w_curN;
  logic [WIDTH-1:0] r_cnt, w_cnt;
  logic [WIDTH-1:0] r_divP, w_divP;
  logic             r_reqReady, w_reqReady;
  logic             r_oddSel, w_oddSel;
  logic             r_coreRst, w_coreRst;
  logic             r_outEn, w_outEn;
  logic             r_locked, w_locked;
  logic             r_err, w_err;
  logic             r_sync1, r_sync2;
  logic             w_accept, w_legal;

  // Odd core counts the full ratio; even core counts half a period.
  function automatic logic [WIDTH-1:0] mapDiv(input logic [WIDTH-1:0] n);
    return n[0] ? n : (n >> 1);
  endfunction

  assign w_accept = req.req_valid & r_reqReady;
  assign w_legal  = (req.req_div >= WIDTH'(2));

  always_comb begin
    w_state    = r_state;
    w_curN     = r_curN;
    w_cnt      = r_cnt;
    w_divP     = r_divP;
    w_reqReady = r_reqReady;
    w_oddSel   = r_oddSel;
    w_coreRst  = r_coreRst;
    w_outEn    = r_outEn;
    w_locked   = r_locked;
    w_err      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_legal) begin
            w_err = 1'b1;
          end else begin
            w_curN     = req.req_div;
            w_divP     = mapDiv(req.req_div);
            w_oddSel   = req.req_div[0];
            w_coreRst  = 1'b1;
            w_cnt      = WIDTH'(RST_CYC);
            w_reqReady = 1'b0;
            w_state    = APPLY;
          end
        end
      end
      RUN: begin
        if (w_accept) begin
          if (!w_legal) begin
            w_err = 1'b1;
          end else if (req.req_div != r_curN) begin
            w_curN     = req.req_div;
            w_locked   = 1'b0;
            w_reqReady = 1'b0;
            w_state    = DRAIN;
          end
        end
      end
      // Gate only while the fed-back clock is low so the output never sees a runt pulse.
      DRAIN: begin
        if (!r_sync2) begin
          w_outEn   = 1'b0;
          w_divP    = mapDiv(r_curN);
          w_oddSel  = r_curN[0];
          w_coreRst = 1'b1;
          w_cnt     = WIDTH'(RST_CYC);
          w_state   = APPLY;
        end
      end
      APPLY: begin
        if (r_cnt == WIDTH'(1)) begin
          w_coreRst = 1'b0;
          w_cnt     = r_curN;
          w_state   = SETTLE;
        end else begin
          w_cnt = r_cnt - WIDTH'(1);
        end
      end
      SETTLE: begin
        if (r_cnt == WIDTH'(1)) begin
          w_outEn    = 1'b1;
          w_locked   = 1'b1;
          w_reqReady = 1'b1;
          w_state    = RUN;
        end else begin
          w_cnt = r_cnt - WIDTH'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_curN     <= '0;
      r_cnt      <= '0;
      r_divP     <= '0;
      r_reqReady <= 1'b1;
      r_oddSel   <= 1'b0;
      r_coreRst  <= 1'b1;
      r_outEn    <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_curN     <= w_curN;
      r_cnt      <= w_cnt;
      r_divP     <= w_divP;
      r_reqReady <= w_reqReady;
      r_oddSel   <= w_oddSel;
      r_coreRst  <= w_coreRst;
      r_outEn    <= w_outEn;
      r_locked   <= w_locked;
      r_err      <= w_err;
      r_sync1    <= i_div_in;
      r_sync2    <= r_sync1;
    end
  end

  assign req.req_ready = r_reqReady;
  assign o_div_p       = r_divP;
  assign o_odd_sel     = r_oddSel;
  assign o_core_rst    = r_coreRst;
  assign o_out_en      = r_outEn;
  assign o_locked      = r_locked;
  assign o_err         = r_err;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Scoreboard bench for div_ratio_ctrl: err pulses and lock events are predicted with their
// exact clock cycle and checked by an independent monitor; static windows are checked inline.
module tb_div_ratio_ctrl;

  typedef struct {
    string       name;
    logic [10:0] vals;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       divIn = 1'b0;
  logic [7:0] divP;
  logic       oddSel, coreRst, outEn, locked, err;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       prevLocked = 1'b0;
  exp_t       expQ[$];

  div_ratio_ctrl_if #(.WIDTH(8)) bus ();

  div_ratio_ctrl #(.WIDTH(8), .RST_CYC(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (bus),
    .i_div_in  (divIn),
    .o_div_p   (divP),
    .o_odd_sel (oddSel),
    .o_core_rst(coreRst),
    .o_out_en  (outEn),
    .o_locked  (locked),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every err pulse or rising lock must match the oldest prediction, cycle included.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (err === 1'b1 || (locked === 1'b1 && prevLocked !== 1'b1))) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedEvent err=%0b locked=%0b cyc=%0d", err, locked, cyc);
      end else begin
        e = expQ.pop_front();
        checks += 2;
        if ({err, locked, oddSel, divP} !== e.vals) begin
          errors++;
          $display("[TB] FAIL %s got=%h expected=%h", e.name, {err, locked, oddSel, divP}, e.vals);
        end
        if (cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL %s_cycle got=%0d expected=%0d", e.name, cyc, e.cyc);
        end
      end
    end
    prevLocked = locked;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  // Issues one request; when hasExp is set, predicts an event lat cycles after the accept edge.
  task automatic applyStimulus(input logic [7:0] n, input bit hasExp, input string name,
                               input logic [10:0] vals, input int lat, output int acc);
    int k;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_div   = n;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) begin
      checkOutput({name, "_readyTimeout"}, 16'(bus.req_ready), 16'd1);
    end
    acc = cyc + 1;
    if (hasExp) begin
      e.name = name;
      e.vals = vals;
      e.cyc  = acc + lat;
      expQ.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int limit);
    int k;
    k = 0;
    while (expQ.size() != 0 && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (expQ.size() != 0) begin
      checkOutput({name, "_eventTimeout"}, 16'(expQ.size()), 16'd0);
      expQ.delete();
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int acc;
    int dropCyc;
    exp_t e;
    bus.req_valid = 1'b0;
    bus.req_div   = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetValues", 16'({bus.req_ready, divP, oddSel, coreRst, outEn, locked, err}),
                16'({1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    reset = 1'b0;

    // Odd ratio from IDLE
    applyStimulus(8'd5, 1'b1, "lockN5", {1'b0, 1'b1, 1'b1, 8'd5}, 7, acc);
    checkOutput("n5Program", 16'({bus.req_ready, divP, oddSel, coreRst}), 16'({1'b0, 8'd5, 1'b1, 1'b1}));
    @(negedge clk);
    checkOutput("n5RstCyc1", 16'(coreRst), 16'd1);
    @(negedge clk);
    checkOutput("n5RstCyc2", 16'(coreRst), 16'd0);
    waitDrain("n5", 40);
    checkOutput("n5Run", 16'({outEn, locked, bus.req_ready}), 16'b111);

    // Even ratio from IDLE
    doReset();
    applyStimulus(8'd6, 1'b1, "lockN6", {1'b0, 1'b1, 1'b0, 8'd3}, 8, acc);
    checkOutput("n6Program", 16'({divP, oddSel}), 16'({8'd3, 1'b0}));
    waitDrain("n6", 40);

    // Illegal ratios in IDLE and in RUN
    doReset();
    applyStimulus(8'd0, 1'b1, "errIdleN0", {1'b1, 1'b0, 1'b0, 8'd0}, 0, acc);
    checkOutput("errIdleReady", 16'(bus.req_ready), 16'd1);
    applyStimulus(8'd1, 1'b1, "errIdleN1", {1'b1, 1'b0, 1'b0, 8'd0}, 0, acc);
    applyStimulus(8'd5, 1'b1, "relockN5", {1'b0, 1'b1, 1'b1, 8'd5}, 7, acc);
    waitDrain("relock5", 40);
    applyStimulus(8'd0, 1'b1, "errRunN0", {1'b1, 1'b1, 1'b1, 8'd5}, 0, acc);
    applyStimulus(8'd1, 1'b1, "errRunN1", {1'b1, 1'b1, 1'b1, 8'd5}, 0, acc);
    checkOutput("errRunSteady", 16'({bus.req_ready, locked, outEn, coreRst}), 16'b1110);
    waitDrain("errs", 10);

    // Reconfigure from RUN with the fed-back clock held high, then released low
    divIn = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(8'd7, 1'b0, "", '0, 0, acc);
    checkOutput("drainEntry", 16'({locked, bus.req_ready, outEn}), 16'b001);
    bus.req_valid = 1'b1;
    bus.req_div   = 8'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("drainHold", 16'({outEn, bus.req_ready, locked, coreRst}), 16'b1000);
    end
    bus.req_valid = 1'b0;
    divIn = 1'b0;
    dropCyc = cyc;
    e.name = "lockN7";
    e.vals = {1'b0, 1'b1, 1'b1, 8'd7};
    e.cyc  = dropCyc + 12;
    expQ.push_back(e);
    repeat (2) begin
      @(negedge clk);
      checkOutput("drainSync", 16'({outEn, bus.req_ready}), 16'b10);
    end
    @(negedge clk);
    checkOutput("drainExit", 16'({outEn, coreRst, divP, oddSel, bus.req_ready}),
                16'({1'b0, 1'b1, 8'd7, 1'b1, 1'b0}));
    waitDrain("n7", 40);

    // New ratio with the clock already low, then a same-ratio no-op
    applyStimulus(8'd9, 1'b1, "lockN9", {1'b0, 1'b1, 1'b1, 8'd9}, 12, acc);
    waitDrain("n9", 40);
    applyStimulus(8'd9, 1'b0, "", '0, 0, acc);
    for (int i = 0; i < 4; i++) begin
      checkOutput("sameNSteady", 16'({bus.req_ready, locked, outEn, coreRst, divP}),
                  16'({1'b1, 1'b1, 1'b1, 1'b0, 8'd9}));
      @(negedge clk);
    end

    // Reset during a long settle, then a fresh lock
    applyStimulus(8'd255, 1'b0, "", '0, 0, acc);
    repeat (20) @(negedge clk);
    checkOutput("settle255", 16'({coreRst, locked, outEn, bus.req_ready, divP, oddSel}),
                16'({4'b0000, 8'd255, 1'b1}));
    #1 reset = 1'b1;
    #1;
    checkOutput("midReset", 16'({bus.req_ready, divP, oddSel, coreRst, outEn, locked, err}),
                16'({1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(8'd3, 1'b1, "lockN3", {1'b0, 1'b1, 1'b1, 8'd3}, 5, acc);
    waitDrain("n3", 40);

    repeat (3) @(negedge clk);
    checkOutput("queueEmpty", 16'(expQ.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
